// File: rtl/fnd_pkg.sv
// Shared constants and pattern helpers for the four-digit FND anode drive.
// Polarity is passed in so every instance can pick its own board wiring.
package fnd_pkg;

  localparam int DIGITS = 4;
  localparam int SEL_W  = 2;

  typedef logic [DIGITS-1:0] digit_t;
  typedef logic [SEL_W-1:0]  sel_t;

  function automatic digit_t off_pattern(input bit active_low);
    return active_low ? '1 : '0;
  endfunction

  // Exactly one bit at its active level; everything else at the OFF level.
  function automatic digit_t on_pattern(input bit active_low, input sel_t idx);
    digit_t onehot;
    onehot = digit_t'(1) << idx;
    return active_low ? ~onehot : onehot;
  endfunction

endpackage

// File: rtl/digit_blank_timer.sv
// Loadable down-counter that holds the display dark for a few cycles after a
// digit change; busy stays high while the count is nonzero.
module digit_blank_timer #(
  parameter int unsigned MAX_COUNT = 1,
  localparam int         W         = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         busy
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/digit_select_decoder.sv
// Registered, enable-gated 2-to-4 digit-select decoder for common-anode FND
// displays, with optional post-change blanking to suppress ghosting.
module digit_select_decoder
  import fnd_pkg::*;
#(
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned BLANK_CYCLES = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_En,
  input  logic [SEL_W-1:0] i_DigitSelect,
  output logic [DIGITS-1:0] o_FND_Digit
);

  localparam bit     BLANK_EN = (BLANK_CYCLES != 0);
  localparam digit_t OFF      = off_pattern(ACTIVE_LOW);

  sel_t idx;
  logic en_hist;
  logic change;
  logic busy;

  // A change is an enable rise or a new index; only meaningful with blanking.
  always_comb begin
    change = 1'b0;
    if (BLANK_EN && i_En) begin
      change = !en_hist || (i_DigitSelect != idx);
    end
  end

  generate
    if (BLANK_EN) begin : g_timer
      localparam int TW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

      // The load edge itself is the first dark cycle, so B-1 more follow it.
      digit_blank_timer #(
        .MAX_COUNT (BLANK_CYCLES)
      ) u_timer (
        .clk        (i_clk),
        .rst        (i_reset),
        .clear      (!i_En),
        .load       (change),
        .load_value (TW'(BLANK_CYCLES - 1)),
        .busy       (busy)
      );
    end else begin : g_no_timer
      assign busy = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_FND_Digit <= OFF;
      idx         <= '0;
      en_hist     <= 1'b0;
    end else if (!i_En) begin
      o_FND_Digit <= OFF;
      en_hist     <= 1'b0;
    end else begin
      en_hist <= 1'b1;
      // Without a change the select already equals idx, so tracking it is safe.
      idx     <= i_DigitSelect;
      if (!BLANK_EN) begin
        o_FND_Digit <= on_pattern(ACTIVE_LOW, i_DigitSelect);
      end else if (change || busy) begin
        o_FND_Digit <= OFF;
      end else begin
        o_FND_Digit <= on_pattern(ACTIVE_LOW, idx);
      end
    end
  end

endmodule

// File: tb/tb_digit_select_decoder.sv
// Directed bench for digit_select_decoder: four instances cover both
// polarities and blank lengths 0, 2 and 3 from shared stimulus.
module tb_digit_select_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] sel;
  logic [3:0] out_b0, out_pol, out_b2, out_b3;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  digit_select_decoder #(.ACTIVE_LOW(1'b1), .BLANK_CYCLES(0)) u_b0 (
    .i_clk(clk), .i_reset(rst), .i_En(en), .i_DigitSelect(sel), .o_FND_Digit(out_b0));
  digit_select_decoder #(.ACTIVE_LOW(1'b0), .BLANK_CYCLES(0)) u_pol (
    .i_clk(clk), .i_reset(rst), .i_En(en), .i_DigitSelect(sel), .o_FND_Digit(out_pol));
  digit_select_decoder #(.ACTIVE_LOW(1'b1), .BLANK_CYCLES(2)) u_b2 (
    .i_clk(clk), .i_reset(rst), .i_En(en), .i_DigitSelect(sel), .o_FND_Digit(out_b2));
  digit_select_decoder #(.ACTIVE_LOW(1'b1), .BLANK_CYCLES(3)) u_b3 (
    .i_clk(clk), .i_reset(rst), .i_En(en), .i_DigitSelect(sel), .o_FND_Digit(out_b3));

  typedef struct {
    logic       en;
    logic [1:0] sel;
    logic [3:0] exp_low;
    logic [3:0] exp_high;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic e, input logic [1:0] s, input int which,
                      input logic [3:0] exp, input string name);
    @(negedge clk);
    en  = e;
    sel = s;
    @(posedge clk);
    #1;
    if (which == 2) check(name, out_b2, exp);
    else            check(name, out_b3, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    sel = 2'd0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] prev_low;

  initial begin
    vecs[0] = '{1'b0, 2'd0, 4'b1111, 4'b0000};
    vecs[1] = '{1'b0, 2'd1, 4'b1111, 4'b0000};
    vecs[2] = '{1'b0, 2'd2, 4'b1111, 4'b0000};
    vecs[3] = '{1'b0, 2'd3, 4'b1111, 4'b0000};
    vecs[4] = '{1'b1, 2'd0, 4'b1110, 4'b0001};
    vecs[5] = '{1'b1, 2'd1, 4'b1101, 4'b0010};
    vecs[6] = '{1'b1, 2'd2, 4'b1011, 4'b0100};
    vecs[7] = '{1'b1, 2'd3, 4'b0111, 4'b1000};
    vecs[8] = '{1'b0, 2'd2, 4'b1111, 4'b0000};
    vecs[9] = '{1'b1, 2'd2, 4'b1011, 4'b0100};

    rst = 1'b1;
    en  = 1'b0;
    sel = 2'd0;
    #12;
    check("reset_b0",  out_b0,  4'b1111);
    check("reset_pol", out_pol, 4'b0000);
    check("reset_b2",  out_b2,  4'b1111);
    check("reset_b3",  out_b3,  4'b1111);
    @(negedge clk);
    rst = 1'b0;

    // Decode table, zero blanking, both polarities; also confirm that the
    // output holds its old value between the input change and the next edge.
    prev_low = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en  = vecs[i].en;
      sel = vecs[i].sel;
      #1;
      check($sformatf("hold_%0d", i), out_b0, prev_low);
      @(posedge clk);
      #1;
      check($sformatf("vec_low_%0d", i),  out_b0,  vecs[i].exp_low);
      check($sformatf("vec_high_%0d", i), out_pol, vecs[i].exp_high);
      prev_low = vecs[i].exp_low;
    end

    // Asynchronous reset pulse between edges, then recovery.
    @(negedge clk);
    en  = 1'b1;
    sel = 2'd3;
    @(posedge clk);
    #1;
    check("pre_reset_b0", out_b0, 4'b0111);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_b0",  out_b0,  4'b1111);
    check("async_reset_pol", out_pol, 4'b0000);
    check("async_reset_b2",  out_b2,  4'b1111);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_b0", out_b0, 4'b0111);

    // Blanking, B=2.
    do_reset();
    step(1'b1, 2'd0, 2, 4'b1111, "b2_rise_0");
    step(1'b1, 2'd0, 2, 4'b1111, "b2_rise_1");
    step(1'b1, 2'd0, 2, 4'b1110, "b2_rise_on");
    step(1'b1, 2'd1, 2, 4'b1111, "b2_chg_0");
    step(1'b1, 2'd1, 2, 4'b1111, "b2_chg_1");
    step(1'b1, 2'd1, 2, 4'b1101, "b2_chg_on");
    step(1'b1, 2'd1, 2, 4'b1101, "b2_steady");
    step(1'b1, 2'd2, 2, 4'b1111, "b2_restart_a");
    step(1'b1, 2'd3, 2, 4'b1111, "b2_restart_b");
    step(1'b1, 2'd3, 2, 4'b1111, "b2_restart_c");
    step(1'b1, 2'd3, 2, 4'b0111, "b2_restart_on");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'(i[0]), 2, 4'b1111, $sformatf("b2_toggle_%0d", i));
    end
    step(1'b1, 2'd0, 2, 4'b1111, "b2_toggle_tail");
    step(1'b1, 2'd0, 2, 4'b1110, "b2_toggle_on");

    // Enable drop mid-blank, B=3.
    do_reset();
    step(1'b1, 2'd2, 3, 4'b1111, "b3_rise_0");
    step(1'b1, 2'd2, 3, 4'b1111, "b3_rise_1");
    step(1'b1, 2'd2, 3, 4'b1111, "b3_rise_2");
    step(1'b1, 2'd2, 3, 4'b1011, "b3_rise_on");
    step(1'b1, 2'd1, 3, 4'b1111, "b3_chg_0");
    step(1'b0, 2'd3, 3, 4'b1111, "b3_drop");
    step(1'b0, 2'd3, 3, 4'b1111, "b3_off");
    step(1'b1, 2'd1, 3, 4'b1111, "b3_rerise_0");
    step(1'b1, 2'd1, 3, 4'b1111, "b3_rerise_1");
    step(1'b1, 2'd1, 3, 4'b1111, "b3_rerise_2");
    step(1'b1, 2'd1, 3, 4'b1101, "b3_rerise_on");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
